// File: rtl/tlb_pkg.sv
// Shared sizing and field types for the TLB set-associative storage.
package tlb_pkg;

    localparam int unsigned NUM_SETS       = 16;
    localparam int unsigned NUM_WAYS       = 4;
    localparam int unsigned SET_INDEX_BITS = 4;
    localparam int unsigned WAY_BITS       = 2;
    localparam int unsigned LRU_BITS       = 4;
    localparam int unsigned VPN_BITS       = 20;
    localparam int unsigned PPN_BITS       = 20;
    localparam int unsigned PERM_BITS      = 2;

    typedef logic [SET_INDEX_BITS-1:0] set_idx_t;
    typedef logic [WAY_BITS-1:0]       way_idx_t;
    typedef logic [LRU_BITS-1:0]       lru_t;
    typedef logic [VPN_BITS-1:0]       vpn_t;
    typedef logic [PPN_BITS-1:0]       ppn_t;
    typedef logic [PERM_BITS-1:0]      perm_t;

    localparam lru_t LRU_MAX = '1;

endpackage

// File: rtl/tlb_lru_sat_inc.sv
// Saturating +1 for an LRU access counter; sticks at all-ones.
module tlb_lru_sat_inc
    import tlb_pkg::*;
(
    input  logic [LRU_BITS-1:0] count,
    output logic [LRU_BITS-1:0] count_inc_c
);

    always_comb begin
        count_inc_c = count;
        if (count != LRU_MAX) begin
            count_inc_c = count + LRU_BITS'(1);
        end
    end

endmodule

// File: rtl/tlb_set_storage.sv
// TLB entry storage: combinational whole-set read, one entry-write port and
// one LRU hit-increment port, all state held in per-field flop arrays.
module tlb_set_storage
    import tlb_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic [SET_INDEX_BITS-1:0] rd_set_index,
    output logic                      rd_valid     [0:NUM_WAYS-1],
    output logic [VPN_BITS-1:0]       rd_vpn       [0:NUM_WAYS-1],
    output logic [PPN_BITS-1:0]       rd_ppn       [0:NUM_WAYS-1],
    output logic [PERM_BITS-1:0]      rd_perms     [0:NUM_WAYS-1],
    output logic [LRU_BITS-1:0]       rd_lru_count [0:NUM_WAYS-1],
    input  logic                      wr_en,
    input  logic                      update_en,
    input  logic [SET_INDEX_BITS-1:0] wr_set_index,
    input  logic [WAY_BITS-1:0]       wr_way,
    input  logic                      wr_valid,
    input  logic [VPN_BITS-1:0]       wr_vpn,
    input  logic [PPN_BITS-1:0]       wr_ppn,
    input  logic [PERM_BITS-1:0]      wr_perms,
    input  logic [LRU_BITS-1:0]       wr_lru_count,
    input  logic                      lru_update_en,
    input  logic [SET_INDEX_BITS-1:0] lru_set_index,
    input  logic [WAY_BITS-1:0]       lru_way
);

    logic  valid_q [NUM_SETS][0:NUM_WAYS-1];
    logic  valid_d [NUM_SETS][0:NUM_WAYS-1];
    vpn_t  vpn_q   [NUM_SETS][0:NUM_WAYS-1];
    vpn_t  vpn_d   [NUM_SETS][0:NUM_WAYS-1];
    ppn_t  ppn_q   [NUM_SETS][0:NUM_WAYS-1];
    ppn_t  ppn_d   [NUM_SETS][0:NUM_WAYS-1];
    perm_t perms_q [NUM_SETS][0:NUM_WAYS-1];
    perm_t perms_d [NUM_SETS][0:NUM_WAYS-1];
    lru_t  lru_q   [NUM_SETS][0:NUM_WAYS-1];
    lru_t  lru_d   [NUM_SETS][0:NUM_WAYS-1];

    logic wr_fire;
    logic lru_hit;
    logic same_entry;
    lru_t lru_old;
    lru_t lru_hit_inc;
    lru_t wr_fill_inc;

    assign rd_valid     = valid_q[rd_set_index];
    assign rd_vpn       = vpn_q[rd_set_index];
    assign rd_ppn       = ppn_q[rd_set_index];
    assign rd_perms     = perms_q[rd_set_index];
    assign rd_lru_count = lru_q[rd_set_index];

    assign wr_fire    = wr_en & update_en;
    assign lru_hit    = lru_update_en & valid_q[lru_set_index][lru_way];
    assign same_entry = (wr_set_index == lru_set_index) && (wr_way == lru_way);
    assign lru_old    = lru_q[lru_set_index][lru_way];

    tlb_lru_sat_inc u_hit_inc (
        .count       (lru_old),
        .count_inc_c (lru_hit_inc)
    );

    // A fill counts as the first access of the new entry.
    tlb_lru_sat_inc u_fill_inc (
        .count       (wr_lru_count),
        .count_inc_c (wr_fill_inc)
    );

    always_comb begin
        valid_d = valid_q;
        vpn_d   = vpn_q;
        ppn_d   = ppn_q;
        perms_d = perms_q;
        lru_d   = lru_q;

        if (lru_hit) begin
            lru_d[lru_set_index][lru_way] = lru_hit_inc;
        end

        // On a same-entry collision with a live entry the hit count wins over the fill base.
        if (wr_fire) begin
            valid_d[wr_set_index][wr_way] = wr_valid;
            vpn_d[wr_set_index][wr_way]   = wr_vpn;
            ppn_d[wr_set_index][wr_way]   = wr_ppn;
            perms_d[wr_set_index][wr_way] = wr_perms;
            lru_d[wr_set_index][wr_way]   = (lru_hit && same_entry) ? lru_hit_inc : wr_fill_inc;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '{default: '0};
            vpn_q   <= '{default: '0};
            ppn_q   <= '{default: '0};
            perms_q <= '{default: '0};
            lru_q   <= '{default: '0};
        end else begin
            valid_q <= valid_d;
            vpn_q   <= vpn_d;
            ppn_q   <= ppn_d;
            perms_q <= perms_d;
            lru_q   <= lru_d;
        end
    end

endmodule

// File: tb/tb_tlb_set_storage.sv
// Self-checking bench for tlb_set_storage: directed scenarios plus random
// write/LRU traffic against an array-based reference model.
module tb_tlb_set_storage;
    import tlb_pkg::*;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [SET_INDEX_BITS-1:0] rd_set_index;
    logic                      rd_valid     [0:NUM_WAYS-1];
    logic [VPN_BITS-1:0]       rd_vpn       [0:NUM_WAYS-1];
    logic [PPN_BITS-1:0]       rd_ppn       [0:NUM_WAYS-1];
    logic [PERM_BITS-1:0]      rd_perms     [0:NUM_WAYS-1];
    logic [LRU_BITS-1:0]       rd_lru_count [0:NUM_WAYS-1];
    logic                      wr_en;
    logic                      update_en;
    logic [SET_INDEX_BITS-1:0] wr_set_index;
    logic [WAY_BITS-1:0]       wr_way;
    logic                      wr_valid;
    logic [VPN_BITS-1:0]       wr_vpn;
    logic [PPN_BITS-1:0]       wr_ppn;
    logic [PERM_BITS-1:0]      wr_perms;
    logic [LRU_BITS-1:0]       wr_lru_count;
    logic                      lru_update_en;
    logic [SET_INDEX_BITS-1:0] lru_set_index;
    logic [WAY_BITS-1:0]       lru_way;

    tlb_set_storage dut (
        .clk           (clk),
        .rst           (rst),
        .rd_set_index  (rd_set_index),
        .rd_valid      (rd_valid),
        .rd_vpn        (rd_vpn),
        .rd_ppn        (rd_ppn),
        .rd_perms      (rd_perms),
        .rd_lru_count  (rd_lru_count),
        .wr_en         (wr_en),
        .update_en     (update_en),
        .wr_set_index  (wr_set_index),
        .wr_way        (wr_way),
        .wr_valid      (wr_valid),
        .wr_vpn        (wr_vpn),
        .wr_ppn        (wr_ppn),
        .wr_perms      (wr_perms),
        .wr_lru_count  (wr_lru_count),
        .lru_update_en (lru_update_en),
        .lru_set_index (lru_set_index),
        .lru_way       (lru_way)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: plain integer arrays indexed [set][way].
    int m_valid [NUM_SETS][NUM_WAYS];
    int m_vpn   [NUM_SETS][NUM_WAYS];
    int m_ppn   [NUM_SETS][NUM_WAYS];
    int m_perms [NUM_SETS][NUM_WAYS];
    int m_lru   [NUM_SETS][NUM_WAYS];

    localparam int LRU_TOP = (1 << LRU_BITS) - 1;

    function automatic int sat1(input int x);
        return (x + 1 > LRU_TOP) ? LRU_TOP : x + 1;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input int exp);
        total++;
        if (got !== 32'(exp)) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int s = 0; s < NUM_SETS; s++) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                m_valid[s][w] = 0;
                m_vpn[s][w]   = 0;
                m_ppn[s][w]   = 0;
                m_perms[s][w] = 0;
                m_lru[s][w]   = 0;
            end
        end
    endtask

    // Next state from the current input values, applied at a rising edge.
    task automatic model_edge();
        int ls  = int'(lru_set_index);
        int lw  = int'(lru_way);
        int ws  = int'(wr_set_index);
        int ww  = int'(wr_way);
        int was_valid = m_valid[ls][lw];
        int old_cnt   = m_lru[ls][lw];
        if (lru_update_en && was_valid != 0) begin
            m_lru[ls][lw] = sat1(old_cnt);
        end
        if (wr_en && update_en) begin
            m_valid[ws][ww] = int'(wr_valid);
            m_vpn[ws][ww]   = int'(wr_vpn);
            m_ppn[ws][ww]   = int'(wr_ppn);
            m_perms[ws][ww] = int'(wr_perms);
            if (lru_update_en && ws == ls && ww == lw && was_valid != 0) begin
                m_lru[ws][ww] = sat1(old_cnt);
            end else begin
                m_lru[ws][ww] = sat1(int'(wr_lru_count));
            end
        end
    endtask

    task automatic idle();
        wr_en         = 1'b0;
        update_en     = 1'b0;
        lru_update_en = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        idle();
    endtask

    task automatic set_write(input int s, input int w, input int v, input int vpn,
                             input int ppn, input int perm, input int wl);
        wr_en        = 1'b1;
        update_en    = 1'b1;
        wr_set_index = SET_INDEX_BITS'(s);
        wr_way       = WAY_BITS'(w);
        wr_valid     = 1'(v);
        wr_vpn       = VPN_BITS'(vpn);
        wr_ppn       = PPN_BITS'(ppn);
        wr_perms     = PERM_BITS'(perm);
        wr_lru_count = LRU_BITS'(wl);
    endtask

    task automatic set_lru(input int s, input int w);
        lru_update_en = 1'b1;
        lru_set_index = SET_INDEX_BITS'(s);
        lru_way       = WAY_BITS'(w);
    endtask

    task automatic check_set(input int s);
        rd_set_index = SET_INDEX_BITS'(s);
        #1;
        for (int w = 0; w < NUM_WAYS; w++) begin
            check($sformatf("s%0d w%0d valid", s, w), 32'(rd_valid[w]), m_valid[s][w]);
            check($sformatf("s%0d w%0d vpn", s, w), 32'(rd_vpn[w]), m_vpn[s][w]);
            check($sformatf("s%0d w%0d ppn", s, w), 32'(rd_ppn[w]), m_ppn[s][w]);
            check($sformatf("s%0d w%0d perms", s, w), 32'(rd_perms[w]), m_perms[s][w]);
            check($sformatf("s%0d w%0d lru", s, w), 32'(rd_lru_count[w]), m_lru[s][w]);
        end
    endtask

    task automatic check_all();
        for (int s = 0; s < NUM_SETS; s++) begin
            check_set(s);
        end
    endtask

    initial begin
        rst = 1'b0;
        rd_set_index = '0;
        idle();
        set_write(0, 0, 0, 0, 0, 0, 0);
        idle();
        set_lru(0, 0);
        idle();
        model_clear();

        // Reset held: everything reads zero.
        repeat (3) @(negedge clk);
        check_all();
        rst = 1'b1;
        @(negedge clk);
        check_all();

        // Single write, fill counts as first access.
        set_write(5, 2, 1, 'hABCDE, 'h12345, 3, 0);
        tick();
        check_set(5);
        rd_set_index = 4'd5;
        #1;
        check("t1 vpn", 32'(rd_vpn[2]), 'hABCDE);
        check("t1 lru", 32'(rd_lru_count[2]), 1);

        // Fill a whole set then overwrite one way.
        for (int w = 0; w < NUM_WAYS; w++) begin
            set_write(3, w, 1, 'h100 + w, 'h200 + w, w, w);
            tick();
        end
        set_write(3, 1, 1, 'hAAAAA, 'hBBBBB, 3, 0);
        tick();
        check_set(3);
        rd_set_index = 4'd3;
        #1;
        check("t2 w1 vpn", 32'(rd_vpn[1]), 'hAAAAA);
        check("t2 w0 vpn", 32'(rd_vpn[0]), 'h100);

        // Enable-qualifier cases must leave state alone.
        set_write(3, 2, 0, 'h55555, 'h66666, 1, 9);
        update_en = 1'b0;
        tick();
        set_write(3, 2, 0, 'h55555, 'h66666, 1, 9);
        wr_en = 1'b0;
        tick();
        check_set(3);

        // Write and hit on the same live entry: count increments from the stored value.
        set_write(7, 0, 1, 'h77777, 'h88888, 2, 0);
        tick();
        set_write(7, 0, 1, 'h77777, 'h88888, 2, 9);
        set_lru(7, 0);
        tick();
        check_set(7);
        rd_set_index = 4'd7;
        #1;
        check("t3 lru", 32'(rd_lru_count[0]), 2);

        // Way 0 of every set.
        for (int i = 0; i < NUM_SETS; i++) begin
            set_write(i, 0, 1, 'h10000 + i, 'h20000 + i, i % 4, 0);
            tick();
        end
        check_all();

        // Saturation, and no increment on an invalid entry.
        for (int i = 0; i < 20; i++) begin
            set_lru(5, 2);
            tick();
        end
        set_lru(9, 3);
        tick();
        check_set(5);
        check_set(9);
        rd_set_index = 4'd5;
        #1;
        check("t5 sat", 32'(rd_lru_count[2]), 15);
        rd_set_index = 4'd9;
        #1;
        check("t5 inv", 32'(rd_lru_count[3]), 0);

        // Fill with a saturated base value.
        set_write(12, 1, 1, 'h12121, 'h34343, 1, 15);
        tick();
        check_set(12);

        // Random traffic with frequent same-entry collisions.
        for (int n = 0; n < 300; n++) begin
            int ws = int'($urandom_range(0, NUM_SETS - 1));
            int ww = int'($urandom_range(0, NUM_WAYS - 1));
            int ls = int'($urandom_range(0, NUM_SETS - 1));
            int lw = int'($urandom_range(0, NUM_WAYS - 1));
            if ($urandom_range(0, 2) == 0) begin
                ls = ws;
                lw = ww;
            end
            set_write(ws, ww, int'($urandom_range(0, 3) != 0), int'($urandom),
                      int'($urandom), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, LRU_TOP)));
            wr_en     = 1'($urandom_range(0, 3) != 0);
            update_en = 1'($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1) begin
                set_lru(ls, lw);
            end
            tick();
            check_set(ws);
            check_set(ls);
        end
        check_all();

        // Asynchronous reset mid-cycle clears state at once.
        #2;
        rst = 1'b0;
        model_clear();
        check_set(0);
        check_set(3);
        check_set(15);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_all();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tlb_set_storage.md
# tlb_set_storage

Set-associative storage array for the TLB: holds per-entry valid, VPN, PPN, permission bits and an LRU access counter for every set and way. It exposes one combinational read port returning all ways of a selected set, one synchronous entry-write port and one synchronous LRU-increment port. It sits beneath the TLB lookup/replacement logic, which performs tag compare and victim selection.

## Interface
- NUM_SETS, 16, number of sets
- NUM_WAYS, 4, associativity
- SET_INDEX_BITS, 4, log2(NUM_SETS)
- LRU_BITS, 4, width of per-entry LRU counter
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- rd_set_index  in  SET_INDEX_BITS  set selected for reading
- rd_valid  out  1 x [0:NUM_WAYS-1]  per-way valid bit of the selected set
- rd_vpn  out  20 x [0:NUM_WAYS-1]  per-way VPN tag
- rd_ppn  out  20 x [0:NUM_WAYS-1]  per-way PPN
- rd_perms  out  2 x [0:NUM_WAYS-1]  per-way permission bits
- rd_lru_count  out  LRU_BITS x [0:NUM_WAYS-1]  per-way LRU counter
- wr_en  in  1  entry write request
- update_en  in  1  write qualifier; a write occurs only when wr_en and update_en are both 1
- wr_set_index  in  SET_INDEX_BITS  target set
- wr_way  in  2  target way
- wr_valid, wr_vpn, wr_ppn, wr_perms  in  1/20/20/2  entry fields to store
- wr_lru_count  in  LRU_BITS  base LRU value for the written entry
- lru_update_en  in  1  LRU hit-increment request
- lru_set_index  in  SET_INDEX_BITS  set of the hit entry
- lru_way  in  2  way of the hit entry

## Operation
- Reset (rst=0): every entry's valid, vpn, ppn, perms, lru_count cleared to 0; all read outputs therefore read 0.
- Read: pure combinational mux of the stored set rd_set_index; all fields are driven regardless of valid.
- Write (wr_en & update_en): at the rising edge, entry [wr_set_index][wr_way] gets wr_valid, wr_vpn, wr_ppn, wr_perms; lru_count := wr_lru_count + 1, saturating at 2^LRU_BITS-1. A fill counts as the first access.
- wr_en without update_en, or update_en without wr_en: no state change.
- LRU update (lru_update_en): at the rising edge, if entry [lru_set_index][lru_way] is valid, lru_count := lru_count + 1, saturating at all-ones. Invalid entries are unchanged.
- Simultaneous write and LRU update to different entries: both take effect.
- Same entry: data fields come from the write; lru_count := old stored count + 1, saturating, and wr_lru_count is ignored. The increment is applied when the entry was valid before the edge; otherwise the write rule applies.
- Other entries are never modified.

## Timing
- Read latency 0; reads reflect state written at the preceding rising edge.
- Write/LRU latency 1 edge; new values are visible on read outputs immediately after that edge.
- Reset asynchronous assert, state held clear while rst=0; first update possible at the first rising edge with rst=1.

## Structure
- Shared package tlb_pkg: NUM_SETS, NUM_WAYS, SET_INDEX_BITS, LRU_BITS, VPN/PPN widths (20), PERM width (2).
- One natural sub-module: tlb_lru_sat_inc (LRU_BITS saturating incrementer). Storage is flip-flop arrays per field, indexed [set][way].

## Test plan
- Reset, then read sets 0..15 -> all rd_valid=0, all fields 0.
- Write set 5 way 2 VPN ABCDE, PPN 12345, perms 11 -> next-cycle read of set 5 gives way 2 valid=1 with those fields and lru_count=1.
- Fill set 3 ways 0..3 with distinct values, then overwrite way 1 with AAAAA/BBBBB/11 -> ways 0, 2, 3 unchanged and way 1 updated.
- Write set 7 way 0 (lru 1), then LRU update set 7 way 0 with wr_en/update_en still high on the same entry -> rd_lru_count[0]=2 and data fields intact.
- Write way 0 of every set with VPN 10000+i, PPN 20000+i -> all 16 read back correctly.
- LRU increment 20 times on one entry -> count saturates at 15; LRU update on an invalid entry -> count stays 0.
